// File: rtl/dmem_ctrl.sv
// Core data-memory controller: aligns loads/stores onto a req/gnt + rvalid memory port.
// Latency: store >=2 stall cycles, load >=3; backpressure by holding mem_req_o until mem_gnt_i, abandoned after TIMEOUT cycles.
module dmem_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_i,
    input  logic        st_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  funct3_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        timeout_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    typedef struct packed {
        logic [29:0] word_addr;
        logic [1:0]  lane;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  funct3;
    } acc_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    acc_t        acc_q, acc_d, acc_new;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q, timeout_d;

    logic        access;
    logic        misaligned;
    logic        last_cycle;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign access     = ld_i | st_i;
    assign last_cycle = (cnt_q == LAST_CNT);

    // Decode the incoming access; a store wins when both requests are high.
    always_comb begin
        acc_new           = '0;
        acc_new.word_addr = addr_i[31:2];
        acc_new.lane      = addr_i[1:0];
        acc_new.we        = st_i;
        acc_new.funct3    = funct3_i;
        misaligned        = 1'b0;
        case (funct3_i[1:0])
            2'b00: begin
                acc_new.be    = 4'b0001 << addr_i[1:0];
                acc_new.wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                acc_new.be    = 4'b0011 << addr_i[1:0];
                acc_new.wdata = {2{wdata_i[15:0]}};
                misaligned    = addr_i[0];
            end
            default: begin
                acc_new.be    = 4'b1111;
                acc_new.wdata = wdata_i;
                misaligned    = (addr_i[1:0] != 2'b00);
            end
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        ld_byte = mem_rdata_i[{acc_q.lane, 3'b000} +: 8];
        ld_half = mem_rdata_i[{acc_q.lane[1], 4'b0000} +: 16];
        case (acc_q.funct3[1:0])
            2'b00:   ld_data = {{24{~acc_q.funct3[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{~acc_q.funct3[2] & ld_half[15]}}, ld_half};
            default: ld_data = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        timeout_d  = timeout_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    acc_d      = acc_new;
                    misalign_d = 1'b0;
                    timeout_d  = 1'b0;
                    if (misaligned) begin
                        state_d    = DONE;
                        misalign_d = 1'b1;
                        rdata_d    = '0;
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_gnt_i && acc_q.we) begin
                    state_d = DONE;
                    rdata_d = '0;
                end else if (last_cycle) begin
                    // A load granted on its very last cycle is abandoned; its late rvalid is ignored.
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    rdata_d   = '0;
                end else if (mem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_rvalid_i) begin
                    state_d = DONE;
                    rdata_d = ld_data;
                end else if (last_cycle) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    rdata_d   = '0;
                end
            end
            DONE: begin
                state_d    = IDLE;
                misalign_d = 1'b0;
                timeout_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

    assign stall_o     = ((state_q == IDLE) && access) || (state_q == REQ) || (state_q == WAIT);
    assign rdata_o     = rdata_q;
    assign misalign_o  = (state_q == DONE) && misalign_q;
    assign timeout_o   = (state_q == DONE) && timeout_q;
    assign mem_req_o   = (state_q == REQ);
    assign mem_we_o    = acc_q.we;
    assign mem_addr_o  = {acc_q.word_addr, 2'b00};
    assign mem_be_o    = acc_q.be;
    assign mem_wdata_o = acc_q.wdata;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, 16, max cycles spent in REQ+WAIT before the access is abandoned (range 2..255).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-high reset; the port keeps the codebase name.
REQ-004 ld_i  input  1  core load request, held stable by core while stall_o=1.
REQ-005 st_i  input  1  core store request (core memwb_o), held stable while stall_o=1.
REQ-006 addr_i  input  32  byte address from core ALU.
REQ-007 wdata_i  input  32  store data from core rs2.
REQ-008 funct3_i  input  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use [1:0] only.
REQ-009 stall_o  output  1  freeze core PC and regfile write.
REQ-010 rdata_o  output  32  aligned, extended load data to core wbdata_i.
REQ-011 misalign_o  output  1  one-cycle pulse, misaligned access dropped.
REQ-012 timeout_o  output  1  one-cycle pulse, access abandoned.
REQ-013 mem_req_o  output  1  memory request valid.
REQ-014 mem_we_o  output  1  memory write enable, valid with mem_req_o.
REQ-015 mem_addr_o  output  32  word address, bits[1:0]=00.
REQ-016 mem_be_o  output  4  byte-lane enables.
REQ-017 mem_wdata_o  output  32  store data shifted to lane.
REQ-018 mem_gnt_i  input  1  memory accepts request this cycle.
REQ-019 mem_rvalid_i  input  1  load data valid.
REQ-020 mem_rdata_i  input  32  load data word.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-022 IDLE: access = ld_i|st_i; st_i takes priority when both high; stall_o SHALL be 1 combinationally when access present in IDLE, REQ or WAIT, 0 in DONE and when idle.
REQ-023 IDLE with access: latch addr, be, shifted wdata, we, funct3; aligned -> REQ; misaligned (half with addr[0]=1, word with addr[1:0]!=00) -> DONE, misalign_o=1 in DONE, no mem_req_o.
REQ-024 mem_be_o: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111; mem_wdata_o replicates byte/half into the addressed lane.
REQ-025 REQ: mem_req_o=1 with latched fields until mem_gnt_i; gnt with we -> DONE; gnt without we -> WAIT.
REQ-026 WAIT: mem_req_o=0; on mem_rvalid_i capture lane-extracted, sign/zero-extended data -> DONE; rvalid in the same cycle as gnt is not sampled.
REQ-027 Cycle counter SHALL clear on entering REQ and increment in REQ and WAIT; reaching TIMEOUT -> DONE, timeout_o=1 in DONE, rdata_o=0.
REQ-028 DONE: lasts exactly one cycle, stall_o=0, rdata_o valid (0 for stores); next state IDLE unconditionally, so the core's next instruction is sampled fresh.
REQ-029 rdata_o SHALL hold its last value outside DONE; mem_rvalid_i outside WAIT SHALL be ignored.
REQ-030 Minimum stall: store 2 cycles (IDLE, REQ with gnt), load 3 cycles (IDLE, REQ, WAIT).

Reset
REQ-031 rst_n=1 at an edge SHALL force IDLE, counter 0, rdata_o=0, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, misalign_o=0, timeout_o=0; stall_o follows REQ-022 from IDLE.
REQ-032 Reset mid-access SHALL abandon it without pulsing timeout_o; late gnt/rvalid after reset SHALL be ignored.

Verification
REQ-033 SW addr 0x100, wdata 0xDEADBEEF, gnt in first REQ cycle -> mem_addr 0x100, be 1111, we=1, stall 2 cycles, DONE next.
REQ-034 LB addr 0x203, mem_rdata 0x80FF_FFFF rvalid 1 cycle after gnt -> rdata_o 0xFFFFFF80; LBU same -> 0x00000080; stall 3 cycles.
REQ-035 SH addr 0x102, wdata 0x0000ABCD -> be 1100, mem_wdata 0xABCDABCD; LH addr 0x101 -> misalign_o pulse, no mem_req_o, stall 1 cycle.
REQ-036 LW with gnt never asserted, TIMEOUT=16 -> timeout_o pulse after 16 REQ cycles, rdata_o=0, FSM returns IDLE.
REQ-037 Reset asserted in WAIT, rvalid arrives the cycle after -> state IDLE, rdata_o stays 0, no DONE cycle.
REQ-038 Back-to-back LW then SW, gnt delayed 3 cycles each -> each access issued exactly once, mem_req_o deasserts between them for at least the DONE and IDLE cycles.
